priority_encoder_pipe: RTL
==========================

// Module: priority_encoder_pipe
// PURPOSE
//   N-input priority encoder with a registered, valid/ready-handshaked output stage.
//   Generalises the fixed 8:3 encoder: width is parametrised, every input pattern is
//   defined (zero and multi-hot are flagged), and the result is buffered under backpressure.
//   Sits between request sources (interrupt lines, arbiter requests) and a downstream consumer.
// PARAMETERS
//   N      8              number of request inputs, N >= 2 (need not be a power of two)
//   IDX_W  $clog2(N)      index width, derived localparam, not overridden
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      in_req is valid this cycle
//   in_ready   out  1      block can accept in_req this cycle
//   in_req     in   N      request vector, bit i = request i
//   out_valid  out  1      out_* holds a result
//   out_ready  in   1      consumer takes the result this cycle
//   out_idx    out  IDX_W  index of the winning request
//   out_zero   out  1      captured in_req was all zeros
//   out_multi  out  1      captured in_req had two or more bits set
// BEHAVIOUR
//   - Reset: out_valid=0, out_idx=0, out_zero=0, out_multi=0 (RR pointer=N-1 if enabled).
//   - in_ready = !out_valid || out_ready (combinational; 1-entry output register).
//   - Accept when in_valid && in_ready; out_* load on that edge; latency 1 cycle.
//   - Hold: out_valid && !out_ready -> all out_* stable, in_req ignored, in_ready=0.
//   - Drain and accept in the same cycle: the old result leaves, the new one loads, out_valid stays 1.
//   - Drain with no new input: out_valid -> 0; out_idx/flags keep their last values.
//   - Fixed priority: the highest set index wins (bit N-1 highest).
//   - in_req==0: out_idx=0, out_zero=1, out_multi=0.
//   - out_multi = popcount(in_req) >= 2, computed on the captured vector.
//   - Non-power-of-two N: out_idx never exceeds N-1.
//   - rst during hold: the pending result is dropped; state follows the reset values above.
//   - rst has priority over every other event in the same cycle.
// CONFIGURATION
//   ROUND_ROBIN_EN defined: rotating priority with an IDX_W-bit pointer ptr.
//     - Search order: ptr, ptr-1, ..., 0, N-1, ..., ptr+1.
//     - On accept with winner g: ptr <= (g==0) ? N-1 : g-1.
//     - Zero request or no accept: ptr unchanged.
//     - Reset ptr=N-1, so the first grant matches fixed priority.
//   ROUND_ROBIN_EN undefined: fixed priority only; no pointer register is built.
//   Flags and the handshake are identical in both builds.
// TESTING
//   1. rst=1 for 2 cycles -> out_valid=0, out_idx=0, flags 0, in_ready=1.
//   2. N=8, in_req=8'b1111_1110, out_ready=1 -> next cycle out_valid=1, out_idx=7,
//      out_multi=1, out_zero=0.
//   3. in_req=8'h01 -> out_idx=0, out_multi=0; then in_req=8'h00 -> out_idx=0, out_zero=1.
//   4. Result 5 held with out_ready=0 for 3 cycles while in_req changes -> in_ready=0 and
//      out_idx=5 stable; then out_ready=1 with in_valid, in_req=8'h08 -> next out_idx=3.
//   5. ROUND_ROBIN_EN, 4 accepts of 8'hFF -> out_idx 7,6,5,4; then 8'h00 then 8'hFF -> 3.
//      Also N=5, in_req=5'b10000 -> out_idx=4.
//   6. rst asserted while a result is held -> next cycle out_valid=0; ptr=N-1 when enabled.

Source files
------------

// File: rtl/priority_encoder_pipe.sv
// rtl/priority_encoder_pipe.sv - N-input priority encoder with a 1-entry valid/ready output register
// Optional rotating priority enabled by defining ROUND_ROBIN_EN.
module priority_encoder_pipe #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_req,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] out_idx,
    output logic                 out_zero,
    output logic                 out_multi
);
    localparam int IDX_W = $clog2(N);

    logic             valid_q, valid_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             zero_q, zero_d;
    logic             multi_q, multi_d;
    logic [IDX_W-1:0] grant;
    logic             any_req;
    logic             accept;

`ifdef ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;
    int               cand;
    logic             found;

    // Walk downward from ptr, wrapping from 0 to N-1; the first set bit wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        cand  = 0;
        for (int j = 0; j < N; j++) begin
            cand = int'(ptr_q) - j;
            if (cand < 0) cand = cand + N;
            if (!found && in_req[cand]) begin
                grant = IDX_W'(cand);
                found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        grant = '0;
        for (int i = 0; i < N; i++) begin
            if (in_req[i]) grant = IDX_W'(i);
        end
    end
`endif

    assign any_req  = |in_req;
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        idx_d   = idx_q;
        zero_d  = zero_q;
        multi_d = multi_q;
`ifdef ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        if (accept) begin
            valid_d = 1'b1;
            idx_d   = any_req ? grant : '0;
            zero_d  = !any_req;
            // Clearing the lowest set bit leaves something only if two or more were set.
            multi_d = |(in_req & (in_req - N'(1)));
`ifdef ROUND_ROBIN_EN
            if (any_req) ptr_d = (grant == '0) ? IDX_W'(N - 1) : grant - IDX_W'(1);
`endif
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            zero_q  <= 1'b0;
            multi_q <= 1'b0;
`ifdef ROUND_ROBIN_EN
            ptr_q   <= IDX_W'(N - 1);
`endif
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
            zero_q  <= zero_d;
            multi_q <= multi_d;
`ifdef ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign out_valid = valid_q;
    assign out_idx   = idx_q;
    assign out_zero  = zero_q;
    assign out_multi = multi_q;
endmodule
